// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares one peripheral port between two masters, one-cycle issue, one-cycle-latency read return
module mmio_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int ADDR_WIDTH     = 26
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_m0_valid,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [31:0]           i_m0_wdata,
    input  logic [3:0]            i_m0_byte_we,
    output logic                  o_m0_ready,
    output logic [31:0]           o_m0_rdata,
    output logic                  o_m0_rvalid,
    input  logic                  i_m1_valid,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [31:0]           i_m1_wdata,
    input  logic [3:0]            i_m1_byte_we,
    output logic                  o_m1_ready,
    output logic [31:0]           o_m1_rdata,
    output logic                  o_m1_rvalid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_data,
    output logic [3:0]            o_byte_we,
    output logic                  o_read_en,
    input  logic [31:0]           i_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t                r_state, w_next;
    logic [1:0]            r_rst_sync;
    logic                  r_last, r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata, r_m0_rdata, r_m1_rdata;
    logic [3:0]            r_be;
    logic                  r_m0_rvalid, r_m1_rvalid;
    logic                  w_idle, w_grant0, w_grant1, w_accept, w_resp;
    // r_last = 1 means master 1 was granted last, so master 0 wins the next tie
    assign w_idle   = (r_state == IDLE) && r_rst_sync[1];
    assign w_grant0 = i_m0_valid && (!i_m1_valid || (FIXED_PRIORITY != 0) || r_last);
    assign w_grant1 = i_m1_valid && !w_grant0;
    assign w_accept = w_idle && (w_grant0 || w_grant1);
    assign w_resp   = (r_state == RESP);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 2'b00;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE) w_next = w_accept ? ISSUE : IDLE;
        else if (r_state == ISSUE) w_next = (r_be == 4'b0000) ? RESP : IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_last  <= w_grant1;
            r_owner <= w_grant1;
            r_addr  <= w_grant1 ? i_m1_addr : i_m0_addr;
            r_wdata <= w_grant1 ? i_m1_wdata : i_m0_wdata;
            r_be    <= w_grant1 ? i_m1_byte_we : i_m0_byte_we;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_resp && !r_owner;
            r_m1_rvalid <= w_resp && r_owner;
            if (w_resp && !r_owner) r_m0_rdata <= i_data;
            if (w_resp && r_owner) r_m1_rdata <= i_data;
        end
    end
    assign o_m0_ready  = w_idle && w_grant0;
    assign o_m1_ready  = w_idle && w_grant1;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_addr      = r_addr;
    assign o_data      = r_wdata;
    assign o_byte_we   = (r_state == ISSUE) ? r_be : 4'b0000;
    assign o_read_en   = (r_state == ISSUE) && (r_be == 4'b0000);
endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter that shares the single memory-mapped peripheral port (GPIO, UART status/data registers) between the CPU data port (master 0) and the debug/loader bridge (master 1). It accepts one request at a time under round-robin or fixed priority, then drives the peripheral port for exactly one issue cycle. It captures the peripheral's one-cycle-latency read data and returns it to the owning master. Only the arbiter drives the peripheral block's address, write-data, byte-enable and read-enable inputs.

## Interface
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = master 0 always wins a tie
- ADDR_WIDTH, 26: peripheral word-address width
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_m0_valid, i_m1_valid  in  1  request valid; held with payload until matching ready
- i_m0_addr, i_m1_addr  in  ADDR_WIDTH  word address
- i_m0_wdata, i_m1_wdata  in  32  write data
- i_m0_byte_we, i_m1_byte_we  in  4  byte write enables; 4'b0000 = read request
- o_m0_ready, o_m1_ready  out  1  accept pulse, combinational from valid and state
- o_m0_rdata, o_m1_rdata  out  32  read data, registered
- o_m0_rvalid, o_m1_rvalid  out  1  one-cycle read-response pulse
- o_addr  out  ADDR_WIDTH  peripheral address
- o_data  out  32  peripheral write data
- o_byte_we  out  4  peripheral byte enables
- o_read_en  out  1  peripheral read strobe (pops UART RX FIFO)
- i_data  in  32  peripheral read data, valid the cycle after issue

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any valid, choose a winner, assert its o_mX_ready, register addr/wdata/byte_we/owner, and go to ISSUE.
  - With no valid, stay in IDLE.
  - Ready is never asserted outside IDLE.
- Arbitration:
  - Single valid wins.
  - Both valid with FIXED_PRIORITY=0: the master not granted last wins.
  - Both valid with FIXED_PRIORITY=1: master 0 wins.
  - The last-grant register updates on every accept.
- ISSUE (one cycle):
  - o_addr, o_data, o_byte_we come from the captured request.
  - o_read_en = 1 only if the captured byte_we == 0.
  - Write: next state IDLE. Read: next state RESP.
- RESP (one cycle):
  - o_byte_we = 0, o_read_en = 0.
  - Sample i_data into the owner's rdata register.
  - Set the owner's rvalid for the next cycle; next state IDLE.
- Outside ISSUE, o_byte_we = 0 and o_read_en = 0.
- o_addr and o_data hold their last issued value.
- o_mX_rdata holds until the next read response to that master.
- The non-owner's rdata and rvalid are untouched.
- Reset: asynchronous assertion forces IDLE immediately, clears all outputs and registers to 0, and sets last-grant to master 1 so master 0 wins the first tie.
  - Any in-flight response is dropped with no rvalid.
  - Release is synchronized to i_clk before the state machine leaves IDLE.

## Timing
- Write: accept in cycle N, peripheral write strobe in cycle N+1, next accept possible in N+2.
  - Throughput is 1 write per 2 cycles.
- Read: accept in N, o_read_en in N+1, i_data sampled at the end of N+2, o_mX_rvalid high in N+3.
  - Next accept possible in N+3, so throughput is 1 read per 3 cycles.
- Every read produces exactly one peripheral read strobe and one rvalid pulse, so no UART RX byte is popped twice or lost.
- A master may raise valid in the same cycle its rvalid is high; it can be accepted that cycle.
- Valid dropped before ready is a protocol violation: the bench flags it; the design is not required to tolerate it.
- A request appearing in ISSUE or RESP waits; it is accepted no earlier than the next IDLE cycle.

## Test plan
- **Single write:** m0 writes addr 0x0, wdata 0xA5A5_0F0F, byte_we 4'b0011.
  - o_m0_ready in cycle 0.
  - Cycle 1: o_addr=0, o_data=0xA5A5_0F0F, o_byte_we=0011, o_read_en=0.
  - Back to IDLE in cycle 2.
- **Single read:** m1 reads addr 0x1 while i_data=0x1234_5678 in the RESP cycle.
  - o_read_en high only in cycle 1.
  - o_m1_rvalid high only in cycle 3, with o_m1_rdata=0x1234_5678.
  - o_m0_rvalid stays 0.
- **Tie, round-robin:** m0 and m1 hold valid reads continuously for 12 cycles.
  - Grants alternate m0, m1, m0, m1 (first after reset is m0).
  - Four accepts, four rvalids, each to the correct master.
- **Tie, FIXED_PRIORITY=1:** both hold valid writes for 6 cycles.
  - m0 is accepted in cycles 0, 2 and 4.
  - m1 is never accepted while m0 stays valid.
  - m1 is accepted in the first IDLE cycle after m0 drops.
- **Reset mid-read:** assert i_rst_n=0 during the RESP cycle.
  - All outputs go to 0 asynchronously, before the next clock edge.
  - No rvalid pulse occurs.
  - After release, a new m0 read completes with normal 3-cycle latency.
- **UART RX pop count:** issue 5 back-to-back m1 reads to addr 0x6.
  - Exactly 5 o_read_en pulses.
  - Exactly 5 o_m1_rvalid pulses, spaced 3 cycles apart.
